// File: rtl/cam_pattern_gen.sv
// OV7670-style camera emulator: drives VSYNC/HREF/pixel bytes (RGB565, high byte first)
// in the PCLK domain with selectable test patterns, for exercising the capture path.
module cam_pattern_gen #(
  parameter int unsigned H_PIX    = 160,
  parameter int unsigned V_LINES  = 120,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned VS_LINES = 3,
  parameter int unsigned V_BACK   = 2,
  parameter int unsigned V_FRONT  = 2
) (
  input  logic        CAM_PCLK,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        CAM_VSYNC,
  output logic        CAM_HREF,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned L       = 2*H_PIX + H_BLANK;
  localparam int unsigned VS_CYC  = VS_LINES*L;
  localparam int unsigned VB_CYC  = V_BACK*L;
  localparam int unsigned VF_CYC  = V_FRONT*L;
  localparam int unsigned M1      = (VS_CYC > VB_CYC) ? VS_CYC : VB_CYC;
  localparam int unsigned M2      = (VF_CYC > H_BLANK) ? VF_CYC : H_BLANK;
  localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BW      = (2*H_PIX > 1) ? $clog2(2*H_PIX) : 1;
  localparam int unsigned YW      = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int unsigned BAR_W   = (H_PIX/8 > 0) ? H_PIX/8 : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bx;
  logic [YW-1:0] y;
  logic [1:0]    mode_q;
  logic [15:0]   color_q;

  function automatic logic [15:0] pixel(input logic [15:0] x, input logic [15:0] yy);
    logic [15:0] bar;
    logic [15:0] p;
    bar = x / 16'(BAR_W);
    p   = '0;
    case (mode_q)
      2'd0: p = color_q;
      2'd1: begin
        case (bar)
          16'd0:   p = 16'hFFFF;
          16'd1:   p = 16'hFFE0;
          16'd2:   p = 16'h07FF;
          16'd3:   p = 16'h07E0;
          16'd4:   p = 16'hF81F;
          16'd5:   p = 16'hF800;
          16'd6:   p = 16'h001F;
          default: p = 16'h0000;
        endcase
      end
      2'd2: p = {x[7:3], yy[6:1], ~x[7:3]};
      default: p = (x[3] ^ yy[3]) ? '1 : '0;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] byte_of(input logic [BW-1:0] b, input logic [YW-1:0] yy);
    logic [15:0] p;
    p = pixel(16'(b >> 1), 16'(yy));
    return b[0] ? p[7:0] : p[15:8];
  endfunction

  // Data is registered from the index of the byte being launched on this edge,
  // so bx/y always name the byte currently on the bus.
  always_ff @(posedge CAM_PCLK or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bx          <= '0;
      y           <= '0;
      mode_q      <= '0;
      color_q     <= '0;
      CAM_VSYNC   <= 1'b0;
      CAM_HREF    <= 1'b0;
      CAM_px_data <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          CAM_VSYNC   <= 1'b0;
          CAM_HREF    <= 1'b0;
          CAM_px_data <= '0;
          if (en) begin
            state     <= S_VSYNC;
            CAM_VSYNC <= 1'b1;
            cnt       <= '0;
            mode_q    <= mode;
            color_q   <= solid_color;
          end
        end
        S_VSYNC: begin
          if (cnt == CW'(VS_CYC - 1)) begin
            CAM_VSYNC <= 1'b0;
            state     <= S_VBACK;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_VBACK: begin
          if (cnt == CW'(VB_CYC - 1)) begin
            state       <= S_ACTIVE;
            CAM_HREF    <= 1'b1;
            bx          <= '0;
            y           <= '0;
            CAM_px_data <= byte_of('0, '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACTIVE: begin
          if (bx == BW'(2*H_PIX - 1)) begin
            state       <= S_HBLANK;
            CAM_HREF    <= 1'b0;
            CAM_px_data <= '0;
            cnt         <= '0;
          end else begin
            bx          <= bx + 1'b1;
            CAM_px_data <= byte_of(bx + 1'b1, y);
          end
        end
        S_HBLANK: begin
          if (cnt == CW'(H_BLANK - 1)) begin
            cnt <= '0;
            if (y == YW'(V_LINES - 1)) begin
              state <= S_VFRONT;
            end else begin
              state       <= S_ACTIVE;
              CAM_HREF    <= 1'b1;
              bx          <= '0;
              y           <= y + 1'b1;
              CAM_px_data <= byte_of('0, y + 1'b1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_VFRONT: begin
          // The done cycle is spent in IDLE, which relaunches VSYNC on the next edge if en is high.
          if (cnt == CW'(VF_CYC - 1)) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cam_pattern_gen.md
# cam_pattern_gen

Synthesizable OV7670-style camera emulator that sits directly upstream of the capture stage. It drives `CAM_VSYNC`, `CAM_HREF` and `CAM_px_data` in the same PCLK domain the capture stage samples, producing frames of known content. Benches and on-board bring-up use it to check the capture/RAM path without a physical sensor. Pixel format is RGB565, high byte first.

## Interface
- `H_PIX`, 160: active pixels per line (each pixel = 2 PCLK bytes)
- `V_LINES`, 120: active lines per frame
- `H_BLANK`, 16: PCLK cycles with HREF low after each line
- `VS_LINES`, 3: line periods with VSYNC high
- `V_BACK`, 2: idle line periods after VSYNC, before the first active line
- `V_FRONT`, 2: idle line periods after the last active line
- `CAM_PCLK`  in  1  pixel clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  run frames continuously while high
- `mode`  in  2  pattern: 0 solid, 1 colour bars, 2 gradient, 3 checker
- `solid_color`  in  16  RGB565 value for mode 0
- `CAM_VSYNC`  out  1  frame sync, active high
- `CAM_HREF`  out  1  high during active bytes of a line
- `CAM_px_data`  out  8  pixel byte
- `frame_done`  out  1  one-cycle pulse after the last V_FRONT cycle
- `frame_cnt`  out  16  completed frames, wraps at 0xFFFF -> 0

## Operation
- Line period L = 2*H_PIX + H_BLANK cycles; default 336. Frame = (VS_LINES+V_BACK+V_LINES+V_FRONT)*L; default 127*336 = 42672 cycles.
- FSM states and transitions:
  - IDLE: all outputs low. Go to VSYNC when `en`=1.
  - VSYNC: CAM_VSYNC=1 for VS_LINES*L cycles, then go to VBACK.
  - VBACK: V_BACK*L cycles, then go to ACTIVE.
  - ACTIVE: HREF=1 for 2*H_PIX cycles, then go to HBLANK.
  - HBLANK: H_BLANK cycles, HREF=0. If the line counter is below V_LINES, go to ACTIVE; otherwise go to VFRONT.
  - VFRONT: V_FRONT*L cycles, then pulse `frame_done`, increment `frame_cnt`, go to VSYNC if `en`, else IDLE.
- Counters:
  - byte counter `bx` spans 0..2*H_PIX-1; pixel x = bx>>1; even bx sends pixel[15:8], odd bx sends pixel[7:0].
  - line counter y spans 0..V_LINES-1.
  - cycle counter for sync and blank periods.
  - All counter widths come from $clog2 of their maxima, with no overflow.
- `mode` and `solid_color` are sampled on entry to VSYNC and held for the whole frame. Changes mid-frame have no effect until the next frame.
- Patterns (x, y zero-based):
  - mode 0: `solid_color`.
  - mode 1: bar = x/(H_PIX/8), 8 bars in order 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000.
  - mode 2: {x[7:3], y[6:1], ~x[7:3]}.
  - mode 3: (x[3]^y[3]) ? 0xFFFF : 0x0000.
- `en` dropping mid-frame: the current frame completes, then the FSM goes to IDLE. It never truncates.

## Timing
- Reset (rst=0, asynchronous): state IDLE; CAM_VSYNC, CAM_HREF, CAM_px_data, frame_done, frame_cnt all 0. This applies immediately, including mid-line.
- All outputs are registered. CAM_px_data changes only on the rising edge and is stable for the full following cycle, so the capture stage samples it on the next edge.
- First VSYNC rise is 1 cycle after `en` is sampled high in IDLE.
- HREF rises and falls in the same cycles as the first and last byte of the line.
- While HREF=0, CAM_px_data = 0.
- VSYNC and HREF are never high simultaneously.
- `frame_done` and the VSYNC rise of the next frame occur in consecutive cycles, with no gap cycles when `en` stays high.

## Test plan
- Reset, `en`=1, `mode`=0, solid_color=0xA5C3, defaults:
  - VSYNC is high 1008 cycles.
  - The first HREF rises 672 cycles after VSYNC falls.
  - Bytes alternate A5, C3 for 320 cycles.
  - 120 HREF pulses per frame.
  - frame_done arrives 42672 cycles after the first VSYNC rise.
- mode=1: line bytes are FF,FF ×20 pixels, then FF,E0 ×20 pixels … ending 00,00 ×20 pixels. Every line is identical.
- mode=3: line 0 pixel 8 = 0xFFFF, pixel 0 = 0x0000; line 8 pixel 0 = 0xFFFF.
- Change mode 0->1 mid-frame: current frame stays solid; next frame is bars. Drop `en` mid-frame: frame completes, frame_done pulses, then outputs stay low.
- Assert rst mid-line: all outputs are 0 in the same cycle. On release with `en`=1, a clean VSYNC restarts the frame and frame_cnt=0.
- Loop into the capture stage: 19200 RAM writes per frame, address ends at 19199, data matches the pattern.
